bitset_pack: RTL and testbench
==============================

Name: bitset_pack

Overview:
- Stream-to-word bit-set assembler; the inverse of the popcount/ctz scanners.
- Accepts a packet of bit indices over a valid/ready handshake and ORs each index into a W-bit word.
- On the packet's last beat, emits the assembled word together with its set-bit count and a duplicate-index flag.
- Feeds the scanners in the logic library and rebuilds masks from index streams produced by ctz-style iterators.

Parameters:
- ORDER, 3, log2 of word width.
- W, 2**ORDER, word width. Localparam, not overridable.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept the input beat.
- in_index  in  ORDER  bit index to set, 0 = LSB.
- in_null  in  1  beat carries no index; in_index is ignored. Used for empty packets or padding.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  assembled word present.
- out_ready  in  1  consumer accepts the word.
- out_word  out  W  assembled bit set.
- out_count  out  ORDER+1  number of set bits in out_word, range 0..W.
- out_dup  out  1  at least one index in the packet was already set when it arrived.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clock. Reset clears acc_word, acc_count, acc_dup, out_word, out_count, out_dup and out_valid to 0.
- in_ready = ~out_valid | out_ready. This is combinational from out_ready.
- in_ready is 1 during reset release and while empty.
- Input accept: in_valid & in_ready on a rising clock edge.
- On accept with in_null=0, let hit = acc_word[in_index]:
  - acc_word[in_index] <= 1.
  - acc_count <= acc_count + (hit ? 0 : 1).
  - acc_dup <= acc_dup | hit.
- On accept with in_null=1: accumulator unchanged, except the last-beat handling below.
- Accepted beat with in_last=1:
  - out_word/out_count/out_dup load the accumulator value including this beat's contribution.
  - out_valid <= 1.
  - acc_word/acc_count/acc_dup clear to 0 in the same edge.
  - Latency: word valid on the cycle after the last beat is accepted.
- Output handshake:
  - out_valid & out_ready completes the transfer.
  - out_valid drops next cycle unless a new last beat is accepted in the same cycle; in that case out_valid stays 1 and out_* take the new packet.
- While out_valid & ~out_ready:
  - in_ready = 0.
  - Accumulator and outputs hold. No input is accepted, including non-last beats.
- out_word, out_count, out_dup are stable while out_valid=1 and not yet accepted.
- Boundary conditions:
  - Packet of a single null last beat → word 0, count 0, dup 0.
  - All W distinct indices → word all ones, count W. out_count must not wrap at W.
  - Repeated index → count unchanged, dup=1, word unchanged.
  - in_valid=0 → no state change regardless of other inputs.
  - Reset mid-packet discards the partial accumulator and any pending output. The first beat after release starts a fresh packet.
- Count arithmetic: ORDER+1 bits, incremented only on a newly set bit. Maximum value is W, so no overflow is possible.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: BITSET_PACK_COUNT_EN.
- Defined: acc_count and out_count are maintained as above.
- Not defined:
  - acc_count register is removed.
  - out_count is tied to 0.
  - out_dup and out_word behaviour is unchanged.

Test Plan (ORDER=3):
- Reset, then packet indices 0,3,7 (last on 7), out_ready=1 → one cycle after the last accept: out_valid=1, out_word=89h, out_count=3, out_dup=0.
- Packet 2,2,5 (last on 5) → out_word=24h, out_count=2, out_dup=1.
- Single beat in_null=1, in_last=1 → out_word=00h, out_count=0, out_dup=0.
- Packet 0..7 ascending (last on 7) → out_word=FFh, out_count=8.
- Backpressure:
  - Packet {1} complete, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and out_word=02h stable throughout.
  - Then out_ready=1 with a last beat index 4 → same-cycle transfer; next cycle out_valid=1, out_word=10h.
- Reset pulse mid-packet after indices 1,6 → all outputs 0. Next packet {3} yields out_word=08h, out_count=1.
- Rebuild without BITSET_PACK_COUNT_EN and repeat the first scenario → out_count=0, out_word=89h.

Source files
------------

// File: rtl/bitset_pack.sv
// Stream-to-word bit-set assembler: ORs a packet of bit indices into a W-bit word.
// Optional set-bit counter enabled by defining BITSET_PACK_COUNT_EN.
module bitset_pack #(
    parameter int ORDER = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ORDER-1:0]      in_index,
    input  logic                  in_null,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(2**ORDER)-1:0] out_word,
    output logic [ORDER:0]        out_count,
    output logic                  out_dup
);
    localparam int W = 2**ORDER;

    logic [W-1:0] acc_word_reg;
    logic         acc_dup_reg;
    logic [W-1:0] out_word_reg;
    logic         out_dup_reg;
    logic         out_valid_reg;

    logic [W-1:0] idx_onehot;
    logic         accept;
    logic         hit;
    logic [W-1:0] word_next;
    logic         dup_next;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_decode
            assign idx_onehot[gi] = (int'(in_index) == gi);
        end
    endgenerate

    // A full output register may only be refilled when it is being drained this cycle.
    assign in_ready  = ~out_valid_reg | out_ready;
    assign accept    = in_valid & in_ready;
    assign hit       = ~in_null & (|(acc_word_reg & idx_onehot));
    assign word_next = in_null ? acc_word_reg : (acc_word_reg | idx_onehot);
    assign dup_next  = acc_dup_reg | hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_word_reg  <= '0;
            acc_dup_reg   <= 1'b0;
            out_word_reg  <= '0;
            out_dup_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    out_word_reg <= word_next;
                    out_dup_reg  <= dup_next;
                    acc_word_reg <= '0;
                    acc_dup_reg  <= 1'b0;
                end else begin
                    acc_word_reg <= word_next;
                    acc_dup_reg  <= dup_next;
                end
            end
            if (accept && in_last) begin
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef BITSET_PACK_COUNT_EN
    logic [ORDER:0] acc_count_reg;
    logic [ORDER:0] out_count_reg;
    logic [ORDER:0] count_next;

    // Only a newly set bit bumps the count, so it tops out at W and cannot wrap.
    assign count_next = acc_count_reg + {{ORDER{1'b0}}, (~in_null & ~hit)};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_count_reg <= '0;
            out_count_reg <= '0;
        end else if (accept) begin
            if (in_last) begin
                out_count_reg <= count_next;
                acc_count_reg <= '0;
            end else begin
                acc_count_reg <= count_next;
            end
        end
    end

    assign out_count = out_count_reg;
`else
    assign out_count = '0;
`endif

    assign out_word  = out_word_reg;
    assign out_dup   = out_dup_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_bitset_pack.sv
// Self-checking bench for bitset_pack (ORDER=3): directed table, hand sequences, random vs model.
// Count expectations follow BITSET_PACK_COUNT_EN (0 when the counter is compiled out).
module tb_bitset_pack;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_index;
    logic       in_null;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic [3:0] out_count;
    logic       out_dup;

    int total = 0;
    int bad   = 0;

    bitset_pack #(.ORDER(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_null   (in_null),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         len;
        int         idx [8];
        bit         nul [8];
        logic [7:0] word;
        int         cnt;
        bit         dup;
    } vec_t;

    typedef struct {
        logic [7:0] word;
        int         cnt;
        bit         dup;
    } exp_t;

    function automatic int ec(int c);
`ifdef BITSET_PACK_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Reference: the word is the set of indices; a duplicate exists iff there are more
    // indices than distinct set bits.
    function automatic exp_t model(int ix[$]);
        exp_t e;
        e.word = '0;
        foreach (ix[i]) e.word = e.word | (8'd1 << ix[i]);
        e.dup = (ix.size() != $countones(e.word));
        e.cnt = ec($countones(e.word));
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called and returning just after a falling edge; holds the beat until accepted.
    task automatic send(int idx, bit nul, bit last, bit ordy);
        int guard = 0;
        in_valid  = 1'b1;
        in_index  = idx[2:0];
        in_null   = nul;
        in_last   = last;
        out_ready = ordy;
        #1;
        while (!in_ready && guard < 50) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clock);
        @(negedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t q[$];
        int   cur[$];
        exp_t e;
        bit   have;
        bit   erdy;
        logic [2:0] bidx;
        bit   bnul, blast;

        tbl[0] = '{3, '{0, 3, 7, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'h89, 3, 1'b0};
        tbl[1] = '{3, '{2, 2, 5, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'h24, 2, 1'b1};
        tbl[2] = '{1, '{6, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0}, 8'h00, 0, 1'b0};
        tbl[3] = '{8, '{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'hFF, 8, 1'b0};
        tbl[4] = '{3, '{7, 3, 1, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0}, 8'h82, 2, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_index = '0; in_null = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_word",  out_word,  0);
        chk("reset_count", out_count, 0);
        chk("reset_dup",   out_dup,   0);
        chk("reset_ready", in_ready,  1);
        reset = 1'b0;
        @(negedge clock);
        #1;

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < tbl[v].len; b++)
                send(tbl[v].idx[b], tbl[v].nul[b], b == tbl[v].len - 1, 1'b1);
            chk($sformatf("tbl%0d_valid", v), out_valid, 1);
            chk($sformatf("tbl%0d_word", v),  out_word,  tbl[v].word);
            chk($sformatf("tbl%0d_count", v), out_count, ec(tbl[v].cnt));
            chk($sformatf("tbl%0d_dup", v),   out_dup,   tbl[v].dup);
            $display("tbl%0d word=%02h count=%0d dup=%0b", v, out_word, out_count, out_dup);
        end

        // Backpressure: output held, non-last beats refused
        idle_cycle();
        send(1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_index = 3'd5; in_null = 1'b0; in_last = 1'b0; out_ready = 1'b0;
            #1;
            chk("bp_in_ready", in_ready,  0);
            chk("bp_valid",    out_valid, 1);
            chk("bp_word",     out_word,  8'h02);
            @(posedge clock);
            @(negedge clock);
            #1;
        end
        send(4, 1'b0, 1'b1, 1'b1);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_word",  out_word,  8'h10);
        chk("bp_next_count", out_count, ec(1));
        chk("bp_next_dup",   out_dup,   0);
        $display("backpressure word=%02h", out_word);

        // Reset mid-packet discards the partial word
        idle_cycle();
        send(1, 1'b0, 1'b0, 1'b1);
        send(6, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_word",  out_word,  0);
        chk("mrst_count", out_count, 0);
        chk("mrst_dup",   out_dup,   0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        chk("mrst_ready", in_ready, 1);
        send(3, 1'b0, 1'b1, 1'b1);
        chk("mrst_valid2", out_valid, 1);
        chk("mrst_word2",  out_word,  8'h08);
        chk("mrst_count2", out_count, ec(1));
        chk("mrst_dup2",   out_dup,   0);
        $display("after reset word=%02h count=%0d", out_word, out_count);
        idle_cycle();

        // Random traffic against the set model with a one-deep output scoreboard
        have = 1'b0; bidx = '0; bnul = 1'b0; blast = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!have) begin
                bidx  = 3'($urandom);
                bnul  = ($urandom % 8) == 0;
                blast = ($urandom % 6) == 0;
                have  = 1'b1;
            end
            out_ready = ($urandom % 4) != 0;
            if (($urandom % 4) != 0) begin
                in_valid = 1'b1; in_index = bidx; in_null = bnul; in_last = blast;
            end else begin
                in_valid = 1'b0; in_index = 3'($urandom); in_null = 1'($urandom);
                in_last = 1'($urandom);
            end
            #1;
            erdy = (q.size() == 0) || out_ready;
            chk("rnd_in_ready", in_ready,  erdy);
            chk("rnd_valid",    out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_word",  out_word,  q[0].word);
                chk("rnd_count", out_count, q[0].cnt);
                chk("rnd_dup",   out_dup,   q[0].dup);
                if (out_ready) q.pop_front();
            end
            if (in_valid && erdy) begin
                if (!bnul) cur.push_back(int'(bidx));
                if (blast) begin
                    e = model(cur);
                    q.push_back(e);
                    cur.delete();
                end
                have = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
